// File: rtl/reg_writeback_queue_pkg.sv
// Shared defaults and types for the register write-back queue.
package reg_writeback_queue_pkg;

  localparam int unsigned WBQ_DEPTH  = 4;
  localparam int unsigned WBQ_ID_W   = 4;
  localparam int unsigned WBQ_DATA_W = 16;
  localparam int unsigned WBQ_RA_ID  = 9;
  localparam int unsigned WBQ_PEND_W = 2;
  localparam int unsigned ZERO_ID    = 0;

  // Source selected by the fixed-priority enqueue arbiter.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LINK,
    SRC_MEM,
    SRC_ALU
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// Generic synchronous FIFO; pointers wrap modulo DEPTH, occupancy kept in its own counter.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// Arbitrates link/mem/alu write requests into a FIFO, drives reg_file write ports,
// and tracks per-register pending writes for decode RAW stalls.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = WBQ_DEPTH,
  parameter int unsigned ID_W   = WBQ_ID_W,
  parameter int unsigned DATA_W = WBQ_DATA_W,
  parameter int unsigned RA_ID  = WBQ_RA_ID,
  parameter int unsigned PEND_W = WBQ_PEND_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       link_valid,
  output logic                       link_ready,
  input  logic [DATA_W-1:0]          link_value,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ID_W-1:0]            mem_id,
  input  logic [DATA_W-1:0]          mem_value,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ID_W-1:0]            alu_id,
  input  logic [DATA_W-1:0]          alu_value,
  input  logic                       issue_valid,
  input  logic [ID_W-1:0]            issue_id,
  input  logic [ID_W-1:0]            rs_id,
  input  logic [ID_W-1:0]            rt_id,
  output logic                       rs_busy,
  output logic                       rt_busy,
  output logic                       control_reg_write,
  output logic [ID_W-1:0]            control_write_id,
  output logic [DATA_W-1:0]          reg_write_value,
  output logic                       ra_write,
  output logic [DATA_W-1:0]          ra_write_value,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       pend_overflow
);

  localparam int unsigned NREG    = 1 << ID_W;
  localparam int unsigned ENTRY_W = 1 + ID_W + DATA_W;
  localparam logic [ID_W-1:0]   RA_REG   = ID_W'(RA_ID);
  localparam logic [ID_W-1:0]   ZERO_REG = ID_W'(ZERO_ID);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef struct packed {
    logic              is_link;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] value;
  } entry_t;

  wb_src_e             w_src;
  entry_t              w_push_entry;
  entry_t              w_head;
  logic [ENTRY_W-1:0]  w_head_bits;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // Readies look only at the registered occupancy, never at this cycle's pop.
  assign link_ready = ~w_full;
  assign mem_ready  = ~w_full & ~link_valid;
  assign alu_ready  = ~w_full & ~link_valid & ~mem_valid;

  always_comb begin
    w_src = SRC_NONE;
    if (link_valid && link_ready)     w_src = SRC_LINK;
    else if (mem_valid && mem_ready)  w_src = SRC_MEM;
    else if (alu_valid && alu_ready)  w_src = SRC_ALU;
  end

  always_comb begin
    w_push_entry = '0;
    case (w_src)
      SRC_LINK: begin
        w_push_entry.is_link = 1'b1;
        w_push_entry.id      = RA_REG;
        w_push_entry.value   = link_value;
      end
      SRC_MEM: begin
        w_push_entry.id    = mem_id;
        w_push_entry.value = mem_value;
      end
      SRC_ALU: begin
        w_push_entry.id    = alu_id;
        w_push_entry.value = alu_value;
      end
      default: w_push_entry = '0;
    endcase
  end

  assign w_push = (w_src != SRC_NONE);
  assign w_pop  = ~w_empty;
  assign w_head = entry_t'(w_head_bits);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_entry),
    .head      (w_head_bits),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      control_reg_write <= 1'b0;
      control_write_id  <= '0;
      reg_write_value   <= '0;
      ra_write          <= 1'b0;
      ra_write_value    <= '0;
    end else begin
      control_reg_write <= 1'b0;
      ra_write          <= 1'b0;
      if (w_pop) begin
        if (w_head.is_link) begin
          ra_write       <= 1'b1;
          ra_write_value <= w_head.value;
        end else if (w_head.id != ZERO_REG) begin
          control_reg_write <= 1'b1;
          control_write_id  <= w_head.id;
          reg_write_value   <= w_head.value;
        end
      end
    end
  end

  logic [PEND_W-1:0] r_pend [NREG];
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;

  // Commits retire from the registered pulse, so a register stays busy through its write cycle.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_inc[i] = issue_valid && (issue_id == ID_W'(i)) && (i != ZERO_ID);
      w_dec[i] = (control_reg_write && (control_write_id == ID_W'(i))) ||
                 (ra_write && (i == RA_ID));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_pend[i] <= '0;
      pend_overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          if (r_pend[i] == PEND_MAX) pend_overflow <= 1'b1;
          else                       r_pend[i] <= r_pend[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  assign rs_busy = (rs_id != ZERO_REG) && (r_pend[rs_id] != '0);
  assign rt_busy = (rt_id != ZERO_REG) && (r_pend[rt_id] != '0);

endmodule
